// File: rtl/vector_id_ex_skid.sv
// ID/EX boundary register for the 8-lane vector datapath.
// A main register feeds EX and a skid register catches one beat while EX stalls.
// in_ready is decoded from the state register only, so it never depends on out_ready.
module vector_id_ex_skid #(
   parameter int unsigned LANE_W = 32,
   parameter int unsigned OP_W   = 5,
   parameter int unsigned RD_W   = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [LANE_W-1:0] in_lane1,
   input  logic [LANE_W-1:0] in_lane2,
   input  logic [LANE_W-1:0] in_lane3,
   input  logic [LANE_W-1:0] in_lane4,
   input  logic [LANE_W-1:0] in_lane5,
   input  logic [LANE_W-1:0] in_lane6,
   input  logic [LANE_W-1:0] in_lane7,
   input  logic [LANE_W-1:0] in_lane8,
   input  logic [OP_W-1:0]   in_op,
   input  logic [RD_W-1:0]   in_rd,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [LANE_W-1:0] out_lane1,
   output logic [LANE_W-1:0] out_lane2,
   output logic [LANE_W-1:0] out_lane3,
   output logic [LANE_W-1:0] out_lane4,
   output logic [LANE_W-1:0] out_lane5,
   output logic [LANE_W-1:0] out_lane6,
   output logic [LANE_W-1:0] out_lane7,
   output logic [LANE_W-1:0] out_lane8,
   output logic [OP_W-1:0]   out_op,
   output logic [RD_W-1:0]   out_rd,
   output logic [1:0]        occupancy
);

   localparam int unsigned BEAT_W = 8 * LANE_W + OP_W + RD_W;

   // Encoding equals the number of held beats, so occupancy is the state itself.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [BEAT_W-1:0]   main_q, main_d;
   logic [BEAT_W-1:0]   skid_q, skid_d;
   logic [BEAT_W-1:0]   in_beat;
   logic                accept;
   logic                drain;

   assign in_beat = {in_lane8, in_lane7, in_lane6, in_lane5,
                     in_lane4, in_lane3, in_lane2, in_lane1, in_op, in_rd};

   assign in_ready  = (state_q != FULL);
   assign out_valid = (state_q != EMPTY);
   assign occupancy = 2'(state_q);
   assign accept    = in_valid & in_ready;
   assign drain     = out_valid & out_ready;

   assign {out_lane8, out_lane7, out_lane6, out_lane5,
           out_lane4, out_lane3, out_lane2, out_lane1, out_op, out_rd} = main_q;

   // Next state and register loads; data registers hold unless explicitly loaded.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         // Kill everything; an offered beat and any queued beats are dropped.
         state_d = EMPTY;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (accept) begin
                  main_d  = in_beat;
                  state_d = ONE;
               end
            end
            ONE: begin
               if (accept && drain) begin
                  main_d = in_beat;
               end else if (accept) begin
                  skid_d  = in_beat;
                  state_d = FULL;
               end else if (drain) begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               if (drain) begin
                  main_d  = skid_q;
                  state_d = ONE;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   // State and payload registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

endmodule

// File: tb/tb_vector_id_ex_skid.sv
// Scoreboard bench for vector_id_ex_skid: a depth-2 queue models the block.
module tb_vector_id_ex_skid;

   typedef struct packed {
      logic [7:0][31:0] lanes;
      logic [4:0]       op;
      logic [3:0]       rd;
   } beat_t;

   localparam int BW = $bits(beat_t);

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, flush, out_valid, out_ready;
   logic [31:0] in_lane1, in_lane2, in_lane3, in_lane4, in_lane5, in_lane6, in_lane7, in_lane8;
   logic [31:0] out_lane1, out_lane2, out_lane3, out_lane4, out_lane5, out_lane6, out_lane7, out_lane8;
   logic [4:0]  in_op, out_op;
   logic [3:0]  in_rd, out_rd;
   logic [1:0]  occupancy;

   beat_t drv;
   beat_t got;
   beat_t sb[$];
   beat_t prev_out;
   logic  hold_chk;
   int    n_vec  = 0;
   int    n_fail = 0;

   always #5 clk = ~clk;

   assign {in_lane8, in_lane7, in_lane6, in_lane5, in_lane4, in_lane3, in_lane2, in_lane1,
           in_op, in_rd} = drv;
   assign got = {out_lane8, out_lane7, out_lane6, out_lane5, out_lane4, out_lane3, out_lane2,
                 out_lane1, out_op, out_rd};

   vector_id_ex_skid dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_lane1(in_lane1), .in_lane2(in_lane2), .in_lane3(in_lane3), .in_lane4(in_lane4),
      .in_lane5(in_lane5), .in_lane6(in_lane6), .in_lane7(in_lane7), .in_lane8(in_lane8),
      .in_op(in_op), .in_rd(in_rd), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_lane1(out_lane1), .out_lane2(out_lane2), .out_lane3(out_lane3), .out_lane4(out_lane4),
      .out_lane5(out_lane5), .out_lane6(out_lane6), .out_lane7(out_lane7), .out_lane8(out_lane8),
      .out_op(out_op), .out_rd(out_rd), .occupancy(occupancy)
   );

   task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // Beat with lane k = base + k - 1.
   function automatic beat_t mk(input int base, input int op, input int rd);
      beat_t b;
      for (int k = 0; k < 8; k++) b.lanes[k] = 32'(base + k);
      b.op = 5'(op);
      b.rd = 4'(rd);
      return b;
   endfunction

   function automatic beat_t rnd_beat();
      beat_t b;
      for (int k = 0; k < 8; k++) b.lanes[k] = $urandom;
      b.op = 5'($urandom);
      b.rd = 4'($urandom);
      return b;
   endfunction

   // One cycle of stimulus; an accepted beat is pushed to the scoreboard.
   task automatic cycle(input logic v, input beat_t b, input logic ordy, input logic fl);
      logic rdy_m;
      @(negedge clk);
      in_valid  = v;
      drv       = b;
      out_ready = ordy;
      flush     = fl;
      rdy_m     = (sb.size() < 2);
      #2;
      if (v && rdy_m && !fl) sb.push_back(b);
   endtask

   // Drop reset between edges while stalled and check the immediate clear.
   task automatic do_reset();
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      flush     = 1'b0;
      #3;
      rst_n = 1'b0;
      #1;
      chk("rst_out_valid", BW'(out_valid), BW'(0));
      chk("rst_occupancy", BW'(occupancy), BW'(0));
      chk("rst_in_ready",  BW'(in_ready),  BW'(1));
      chk("rst_outputs",   got,            '0);
      sb.delete();
      hold_chk = 1'b0;
      repeat (2) @(negedge clk);
      #3;
      rst_n = 1'b1;
   endtask

   // Monitor: compare presented state against the model, pop on handshake.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (rst_n) begin
            chk("out_valid", BW'(out_valid), BW'(sb.size() != 0));
            chk("occupancy", BW'(occupancy), BW'(sb.size()));
            chk("in_ready",  BW'(in_ready),  BW'(sb.size() < 2));
            if (sb.size() != 0) chk("out_beat", got, sb[0]);
            else if (hold_chk)  chk("idle_hold", got, prev_out);
            prev_out = got;
            hold_chk = 1'b1;
            if (sb.size() != 0 && out_ready) void'(sb.pop_front());
            if (flush) sb.delete();
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int pct;
      beat_t idle;
      idle      = '0;
      hold_chk  = 1'b0;
      prev_out  = '0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      flush     = 1'b0;
      drv       = '0;
      repeat (2) @(negedge clk);
      #3;
      rst_n = 1'b1;

      // A little traffic, then reset mid-run and a single beat.
      cycle(1'b1, mk(100, 1, 1), 1'b0, 1'b0);
      do_reset();
      cycle(1'b1, mk(1, 3, 2), 1'b1, 1'b0);

      // Streaming at full rate.
      for (int i = 9; i <= 12; i++) cycle(1'b1, mk(i, i, i), 1'b1, 1'b0);
      cycle(1'b0, idle, 1'b1, 1'b0);
      cycle(1'b0, idle, 1'b1, 1'b0);

      // Stall and skid, then release.
      cycle(1'b1, mk(13, 4, 5), 1'b0, 1'b0);
      cycle(1'b1, mk(14, 6, 7), 1'b0, 1'b0);
      cycle(1'b0, idle, 1'b0, 1'b0);
      cycle(1'b0, idle, 1'b1, 1'b0);
      cycle(1'b0, idle, 1'b1, 1'b0);
      cycle(1'b0, idle, 1'b1, 1'b0);

      // Flush while full with a beat offered.
      cycle(1'b1, mk(20, 1, 1), 1'b0, 1'b0);
      cycle(1'b1, mk(21, 2, 2), 1'b0, 1'b0);
      cycle(1'b1, mk(15, 3, 3), 1'b0, 1'b1);
      cycle(1'b0, idle, 1'b1, 1'b0);
      cycle(1'b0, idle, 1'b1, 1'b0);

      // Flush coinciding with drain.
      cycle(1'b1, mk(30, 8, 9), 1'b0, 1'b0);
      cycle(1'b0, idle, 1'b1, 1'b1);
      cycle(1'b0, idle, 1'b1, 1'b0);
      cycle(1'b0, idle, 1'b1, 1'b0);

      // Asynchronous reset while full.
      cycle(1'b1, mk(40, 1, 2), 1'b0, 1'b0);
      cycle(1'b1, mk(41, 3, 4), 1'b0, 1'b0);
      do_reset();

      // Randomized traffic with varying back-pressure.
      for (int i = 0; i < 3000; i++) begin
         if (i % 200 == 0) pct = 20 + 30 * ((i / 200) % 3);
         cycle(1'($urandom_range(99) < 70), rnd_beat(),
               1'($urandom_range(99) < pct), 1'($urandom_range(99) < 4));
         if (i == 1500) do_reset();
      end
      cycle(1'b0, idle, 1'b1, 1'b0);
      cycle(1'b0, idle, 1'b1, 1'b0);
      cycle(1'b0, idle, 1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/vector_id_ex_skid.md
Name: vector_id_ex_skid

Overview:
- ID/EX pipeline boundary register for the 8-lane vector datapath.
- Captures the eight 32-bit operand lanes from the ID-stage vector data mux, plus opcode and destination register tag.
- Presents them to EX under a valid/ready handshake.
- A 2-entry skid buffer absorbs one extra beat when EX stalls, so in_ready is purely registered and has no combinational path from out_ready.

Parameters:
- LANE_W, 32, width of each vector lane.
- OP_W, 5, width of the opcode field carried alongside the data.
- RD_W, 4, width of the destination vector register tag.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  ID presents a beat.
- in_ready  output  1  block can accept a beat this cycle.
- in_lane1..in_lane8  input  LANE_W each  operand lanes from the vector data mux outputs.
- in_op  input  OP_W  opcode of the beat.
- in_rd  input  RD_W  destination tag of the beat.
- flush  input  1  synchronous pipeline flush (branch/hazard kill).
- out_valid  output  1  EX-side beat valid.
- out_ready  input  1  EX can consume a beat.
- out_lane1..out_lane8  output  LANE_W each  registered operand lanes to EX.
- out_op  output  OP_W  registered opcode.
- out_rd  output  RD_W  registered destination tag.
- occupancy  output  2  number of held beats (0, 1 or 2).

Behaviour:
- Storage:
  - Main register drives all out_* signals.
  - Skid register holds one overflow beat.
- State machine (3 states):
  - EMPTY: occupancy 0.
  - ONE: main valid, occupancy 1.
  - FULL: main and skid valid, occupancy 2.
- Derived signals:
  - out_valid = (state != EMPTY).
  - in_ready = (state != FULL); decoded from the state register only.
  - accept = in_valid & in_ready.
  - drain = out_valid & out_ready.
- Transitions when flush = 0:
  - EMPTY: accept loads main, goes to ONE; else stays EMPTY.
  - ONE, accept & drain: new beat loads main, stays ONE (full throughput, 1 beat/cycle).
  - ONE, accept & !drain: new beat loads skid, goes to FULL; main unchanged.
  - ONE, !accept & drain: goes to EMPTY.
  - ONE, idle: holds.
  - FULL, drain: main <= skid, goes to ONE (accept impossible since in_ready = 0).
  - FULL, !drain: holds, all outputs stable.
- Latency: a beat accepted at edge N is on out_* from edge N onward (1 cycle).
- Ordering: strict FIFO; the skid beat is never presented before the main beat.
- Stability: while out_valid = 1 and out_ready = 0, all out_* are held bit-exact.
- Data registers are only written on a load; otherwise they hold. Data is don't-care when the matching valid is 0, but it must not change on idle cycles.
- flush:
  - Highest priority: next state EMPTY regardless of accept/drain.
  - A beat offered in the flush cycle is discarded.
  - If drain coincides with flush, the current main beat counts as consumed by EX; the block takes no further action.
  - in_ready is 1 on the cycle after a flush.
- Reset (rst_n low, any time, including mid-stall):
  - State EMPTY, out_valid 0, in_ready 1, occupancy 0.
  - All lane, op and rd registers (main and skid) cleared to 0.
  - Deassertion takes effect on the first rising edge with rst_n high.
- Lanes pass through unmodified; no arithmetic or width change.

Test Plan:
- Reset then single beat:
  - Stimulus: assert rst_n low mid-run.
  - Required: out_valid = 0, occupancy = 0, all out_lane = 0.
  - Stimulus: release reset, drive lanes 1..8 = 32'd1..32'd8, op = 5'd3, rd = 4'd2 with out_ready = 1.
  - Required: next cycle out_lane1..8 = 1..8, out_valid = 1.
- Streaming:
  - Stimulus: 4 back-to-back beats (lane1 = 9, 10, 11, 12) with out_ready held 1.
  - Required: in_ready stays 1, occupancy stays 1, EX sees 9, 10, 11, 12 on consecutive cycles.
- Stall and skid:
  - Stimulus: out_ready = 0 while beats A (lane1 = 13) and B (lane1 = 14) are offered.
  - Required: occupancy goes 1 then 2, in_ready = 0, out_lane1 = 13 held.
  - Stimulus: raise out_ready.
  - Required: 13 then 14 delivered, in_ready returns to 1 one cycle after the first drain.
- Flush in FULL:
  - Stimulus: with occupancy 2, pulse flush while in_valid = 1 offers lane1 = 15.
  - Required: next cycle out_valid = 0, occupancy = 0, in_ready = 1; beat 15 never appears.
- Flush with drain:
  - Stimulus: occupancy 1, flush = 1 and out_ready = 1 in the same cycle.
  - Required: beat consumed once, then EMPTY; no duplicate beat.
- Asynchronous reset mid-stall:
  - Stimulus: occupancy 2, drop rst_n between clock edges.
  - Required: out_valid and occupancy go to 0 immediately without a clock edge, and all outputs read 0.
